// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and helpers for the writeback path.
// The write arbiter uses the x0 index and the one-hot enable decoder.
package regfile_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 5;
  localparam int NUM_REGS       = 32;

  localparam int SP_INDEX       = 2;
  localparam logic [DATA_WIDTH-1:0] SP_RESET = 32'h7FFF_EFFC;
  localparam int ZERO_INDEX     = 0;

  localparam int DROP_CNT_WIDTH = 8;

  // Per-register write enable for a destination index.
  function automatic logic [NUM_REGS-1:0] onehot_decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between requesters, the write arbiter and the register file.
// master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic [DATA_WIDTH-1:0]         wr_D;
  logic [NREGS-1:0]              wr_en;
  logic                          fwd_valid;
  logic [ADDR_WIDTH-1:0]         fwd_addr;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_D, wr_en, fwd_valid, fwd_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_D, wr_en, fwd_valid, fwd_addr
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid request at or after ptr,
// wrapping modulo N. hold suppresses every grant.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          hold,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = PW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources:
// round-robin grant, one registered write per cycle, x0 writes counted and dropped.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  regfile_write_arbiter_if.slave bus,
  output logic [7:0]             drop_cnt
);

  import regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] DROP_SAT = 8'hFF;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_nxt;
  logic [PW-1:0]         gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  accept;
  logic                  acc_zero;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  logic [DATA_WIDTH-1:0] wr_d_q;
  logic [NREGS-1:0]      wr_en_q;
  logic                  fwd_valid_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;

  // Reset also masks the grant so nothing reads as accepted while rst is low.
  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .hold    (hold || !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;
  assign acc_addr      = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign acc_data      = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign acc_zero      = (acc_addr == ADDR_WIDTH'(ZERO_INDEX));
  assign ptr_nxt       = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PW'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      wr_d_q      <= '0;
      wr_en_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      drop_cnt    <= '0;
    end else begin
      wr_en_q     <= '0;
      fwd_valid_q <= 1'b0;
      if (accept) begin
        ptr <= ptr_nxt;
        if (acc_zero) begin
          if (drop_cnt != DROP_SAT) drop_cnt <= drop_cnt + 8'd1;
        end else begin
          wr_en_q     <= onehot_decode(acc_addr);
          wr_d_q      <= acc_data;
          fwd_valid_q <= 1'b1;
          fwd_addr_q  <= acc_addr;
        end
      end
    end
  end

  assign bus.wr_D      = wr_d_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_addr  = fwd_addr_q;

  a_wr_en_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(wr_en_q) && !wr_en_q[ZERO_INDEX]);

  // A pending request must not change under the arbiter until it is taken.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_contract
    a_req_stable: assert property (@(posedge clk) disable iff (!rst)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
        (bus.req_valid[i]
         && $stable(bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
         && $stable(bus.req_data[i*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, rotation, single write,
// x0 drop saturation, hold and asynchronous reset mid-stream.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  logic [31:0] exp_en  [4];
  logic [31:0] exp_d   [4];
  logic [2:0]  exp_rdy [4];

  initial begin
    rst           = 1'b0;
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // Reset with everyone requesting
    set_req(0, 1'b1, 5'd3, 32'hA000_0003);
    set_req(1, 1'b1, 5'd4, 32'hB000_0004);
    set_req(2, 1'b1, 5'd6, 32'hC000_0006);
    #12;
    check("rst_ready",     bus.req_ready, 3'b000);
    check("rst_wr_en",     bus.wr_en, 32'h0);
    check("rst_drop_cnt",  drop_cnt, 8'd0);
    check("rst_fwd_valid", bus.fwd_valid, 1'b0);
    check("rst_wr_D",      bus.wr_D, 32'h0);
    check("rst_fwd_addr",  bus.fwd_addr, 5'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rel_ready_req0", bus.req_ready, 3'b001);

    // Contention: strict rotation 0,1,2,0
    exp_en[0] = 32'h08; exp_d[0] = 32'hA000_0003; exp_rdy[0] = 3'b010;
    exp_en[1] = 32'h10; exp_d[1] = 32'hB000_0004; exp_rdy[1] = 3'b100;
    exp_en[2] = 32'h40; exp_d[2] = 32'hC000_0006; exp_rdy[2] = 3'b001;
    exp_en[3] = 32'h08; exp_d[3] = 32'hA000_0003; exp_rdy[3] = 3'b010;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rot%0d_wr_en", c), bus.wr_en, exp_en[c]);
      check($sformatf("rot%0d_wr_D", c), bus.wr_D, exp_d[c]);
      check($sformatf("rot%0d_fwd_valid", c), bus.fwd_valid, 1'b1);
      check($sformatf("rot%0d_ready", c), bus.req_ready, exp_rdy[c]);
    end

    // Drain, each requester leaving right after its own accept
    step();
    check("drain1_wr_en", bus.wr_en, 32'h10);
    set_req(1, 1'b0, 5'd4, 32'hB000_0004);
    #1 check("drain1_ready", bus.req_ready, 3'b100);
    step();
    check("drain2_wr_en", bus.wr_en, 32'h40);
    set_req(2, 1'b0, 5'd6, 32'hC000_0006);
    #1 check("drain2_ready", bus.req_ready, 3'b001);
    step();
    check("drain0_wr_en", bus.wr_en, 32'h08);
    check("drain0_fwd_addr", bus.fwd_addr, 5'd3);
    set_req(0, 1'b0, 5'd3, 32'hA000_0003);
    step();
    check("idle_wr_en",     bus.wr_en, 32'h0);
    check("idle_fwd_valid", bus.fwd_valid, 1'b0);
    check("idle_wr_D_hold", bus.wr_D, 32'hA000_0003);
    check("idle_fwd_addr_hold", bus.fwd_addr, 5'd3);

    // Single write from req1 (ptr now 1)
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1 check("single_ready", bus.req_ready, 3'b010);
    step();
    check("single_wr_en",     bus.wr_en, 32'h0000_0020);
    check("single_wr_D",      bus.wr_D, 32'hDEAD_BEEF);
    check("single_fwd_addr",  bus.fwd_addr, 5'd5);
    check("single_fwd_valid", bus.fwd_valid, 1'b1);
    set_req(1, 1'b0, 5'd5, 32'hDEAD_BEEF);
    step();
    check("single_after_wr_en", bus.wr_en, 32'h0);

    // x0 writes: accepted, dropped, counted with saturation
    set_req(0, 1'b1, 5'd0, 32'd1234);
    #1 check("x0_ready", bus.req_ready, 3'b001);
    step();
    check("x0_wr_en",     bus.wr_en, 32'h0);
    check("x0_fwd_valid", bus.fwd_valid, 1'b0);
    check("x0_drop_cnt1", drop_cnt, 8'd1);
    for (int n = 2; n <= 254; n++) step();
    check("x0_drop_cnt254", drop_cnt, 8'd254);
    step();
    check("x0_drop_cnt255", drop_cnt, 8'd255);
    for (int n = 256; n <= 300; n++) step();
    check("x0_drop_cnt300", drop_cnt, 8'd255);
    check("x0_sat_wr_en",   bus.wr_en, 32'h0);
    set_req(0, 1'b0, 5'd0, 32'd1234);

    // hold right after an accept (ptr 1 -> req1 first)
    set_req(0, 1'b1, 5'd10, 32'hC5C5_0000);
    set_req(1, 1'b1, 5'd9,  32'hA5A5_0000);
    set_req(2, 1'b1, 5'd7,  32'hB5B5_0000);
    #1 check("hold_pre_ready", bus.req_ready, 3'b010);
    step();
    set_req(1, 1'b0, 5'd9, 32'hA5A5_0000);
    hold = 1'b1;
    #1;
    check("hold_inflight_wr_en", bus.wr_en, 32'h0000_0200);
    check("hold_ready0",         bus.req_ready, 3'b000);
    for (int h = 0; h < 4; h++) begin
      step();
      check($sformatf("hold%0d_ready", h), bus.req_ready, 3'b000);
      check($sformatf("hold%0d_wr_en", h), bus.wr_en, 32'h0);
    end
    hold = 1'b0;
    #1 check("unhold_ready_req2", bus.req_ready, 3'b100);
    step();
    check("unhold_wr_en", bus.wr_en, 32'h0000_0080);
    check("unhold_wr_D",  bus.wr_D, 32'hB5B5_0000);
    set_req(2, 1'b0, 5'd7, 32'hB5B5_0000);
    #1 check("unhold_ready_req0", bus.req_ready, 3'b001);
    step();
    check("unhold_req0_wr_en", bus.wr_en, 32'h0000_0400);
    set_req(0, 1'b0, 5'd10, 32'hC5C5_0000);

    // Async reset while a write to x2 is in the output stage
    set_req(1, 1'b1, 5'd2, 32'hD6D6_0000);
    set_req(2, 1'b1, 5'd8, 32'hE6E6_0000);
    #1 check("arst_pre_ready", bus.req_ready, 3'b010);
    step();
    check("arst_inflight_wr_en", bus.wr_en, 32'h0000_0004);
    set_req(1, 1'b0, 5'd2, 32'hD6D6_0000);
    set_req(0, 1'b1, 5'd11, 32'hF6F6_0000);
    #2 rst = 1'b0;
    #1;
    check("arst_wr_en",     bus.wr_en, 32'h0);
    check("arst_fwd_valid", bus.fwd_valid, 1'b0);
    check("arst_ready",     bus.req_ready, 3'b000);
    check("arst_drop_cnt",  drop_cnt, 8'd0);
    #2 rst = 1'b1;
    #1 check("arst_rel_ready_req0", bus.req_ready, 3'b001);
    step();
    check("arst_rel_wr_en", bus.wr_en, 32'h0000_0800);
    check("arst_rel_wr_D",  bus.wr_D, 32'hF6F6_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
